// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select between four requesters, with a registered valid/ready output stage.
// Optional per-source burst lock: define MUX_ARB_LOCK_EN to add the lock input.
module mux_rr_arbiter #(
   parameter int W     = 8,
   parameter int BURST = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   req,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [W-1:0] C,
   input  logic [W-1:0] D,
   output logic [W-1:0] Q,
   output logic         q_valid,
   input  logic         q_ready,
   output logic [3:0]   grant,
   output logic [1:0]   sel,
`ifdef MUX_ARB_LOCK_EN
   input  logic [3:0]   lock,
`endif
   output logic         beat_taken
);

   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t         state_reg, state_next;
   logic [W-1:0]   q_reg, q_next;
   logic           q_valid_reg, q_valid_next;
   logic [3:0]     grant_reg, grant_next;
   logic [1:0]     sel_reg, sel_next;
   logic [1:0]     last_reg, last_next;
   logic [CW-1:0]  cnt_reg, cnt_next;

   logic [W-1:0]   src [4];
   logic [1:0]     base;
   logic [1:0]     cand [4];
   logic [1:0]     winner;
   logic           any_req;
   logic           xfer;
   logic           keep;

   assign src[0] = A;
   assign src[1] = B;
   assign src[2] = C;
   assign src[3] = D;

   // In SERVE the owner becomes the new "last" at the rearbitration edge.
   assign base    = (state_reg == SERVE) ? sel_reg : last_reg;
   assign any_req = |req;
   assign xfer    = q_valid_reg && q_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand[gi] = base + 2'(gi + 1);
      end
   endgenerate

   always_comb begin
      winner = base;
      for (int i = 3; i >= 0; i--) begin
         if (req[cand[i]]) winner = cand[i];
      end
   end

`ifdef MUX_ARB_LOCK_EN
   assign keep = req[sel_reg] && ((cnt_reg < BURST_C) || lock[sel_reg]);
`else
   assign keep = req[sel_reg] && (cnt_reg < BURST_C);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         q_reg       <= '0;
         q_valid_reg <= 1'b0;
         grant_reg   <= '0;
         sel_reg     <= '0;
         last_reg    <= 2'd3;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         q_reg       <= q_next;
         q_valid_reg <= q_valid_next;
         grant_reg   <= grant_next;
         sel_reg     <= sel_next;
         last_reg    <= last_next;
         cnt_reg     <= cnt_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next   = state_reg;
      q_next       = q_reg;
      q_valid_next = q_valid_reg;
      grant_next   = grant_reg;
      sel_next     = sel_reg;
      last_next    = last_reg;
      cnt_next     = cnt_reg;
      case (state_reg)
         IDLE: begin
            grant_next = '0;
            if (any_req) begin
               state_next   = SERVE;
               sel_next     = winner;
               grant_next   = 4'b0001 << winner;
               q_next       = src[winner];
               q_valid_next = 1'b1;
               cnt_next     = CW'(1);
            end
         end
         SERVE: begin
            if (xfer) begin
               if (keep) begin
                  q_next = src[sel_reg];
                  if (cnt_reg < BURST_C) cnt_next = cnt_reg + CW'(1);
               end else begin
                  last_next = sel_reg;
                  if (any_req) begin
                     sel_next     = winner;
                     grant_next   = 4'b0001 << winner;
                     q_next       = src[winner];
                     q_valid_next = 1'b1;
                     cnt_next     = CW'(1);
                  end else begin
                     state_next   = IDLE;
                     q_valid_next = 1'b0;
                     grant_next   = '0;
                     cnt_next     = '0;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic; a beat is never accepted while reset is asserted.
   always_comb begin
      Q          = q_reg;
      q_valid    = q_valid_reg;
      grant      = grant_reg;
      sel        = sel_reg;
      beat_taken = q_valid_reg && q_ready && !reset;
   end

endmodule
